// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for the renamed 5-stage RV32I core.
//
// Purpose:
//   Tracks which physical registers still have an in-flight producer
//   (busy scoreboard). Stalls the ID instruction when a source can
//   neither be read from the PRF nor forwarded by the time it reaches EX.
//   Sequences the pipeline register enables, bubbles and flushes for
//   three events: data-memory waits, EX redirects and source hazards.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid, id_rs{1,2}_used/_tag  ID instruction and its sources
//   alloc_valid, alloc_tag          destination allocated for the ID instr
//   ex_we, ex_is_load, ex_dest_tag  producer currently in ID/EX
//   mem_we, mem_dest_tag            producer currently in EX/MEM
//   wb_valid, wb_tag                PRF write happening this cycle
//   dmem_stall                      MEM waiting on data memory
//   redirect, squash_valid/_tag     EX mispredict, killed ID destination
//   *_we, id_ex_bubble, if_id_flush pipeline register control
//   busy_vec                        scoreboard state
//   stall_cycles                    wrapping count of cycles with if_id_we=0
module hazard_ctrl #(
  parameter int NUM_PHYS = 64,
  parameter int TAG_W    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [TAG_W-1:0]    id_rs1_tag,
  input  logic [TAG_W-1:0]    id_rs2_tag,
  input  logic                alloc_valid,
  input  logic [TAG_W-1:0]    alloc_tag,
  input  logic                ex_we,
  input  logic                ex_is_load,
  input  logic [TAG_W-1:0]    ex_dest_tag,
  input  logic                mem_we,
  input  logic [TAG_W-1:0]    mem_dest_tag,
  input  logic                wb_valid,
  input  logic [TAG_W-1:0]    wb_tag,
  input  logic                dmem_stall,
  input  logic                redirect,
  input  logic                squash_valid,
  input  logic [TAG_W-1:0]    squash_tag,
  output logic                pc_we,
  output logic                if_id_we,
  output logic                id_ex_we,
  output logic                ex_mem_we,
  output logic                mem_wb_we,
  output logic                id_ex_bubble,
  output logic                if_id_flush,
  output logic [NUM_PHYS-1:0] busy_vec,
  output logic [31:0]         stall_cycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                flush_pending_q, flush_pending_d;
  logic [NUM_PHYS-1:0] busy_q, busy_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;

  // ---------------------------------------------------------------------
  // Source hazard detection
  // ---------------------------------------------------------------------
  // A load in ID/EX never forwards from EX/MEM (its data arrives in WB),
  // so an ID/EX match only counts as forwardable for non-loads.
  logic rs1_fwd, rs2_fwd, rs1_haz, rs2_haz, hazard;

  assign rs1_fwd = (ex_we && !ex_is_load && (id_rs1_tag == ex_dest_tag)) ||
                   (mem_we && (id_rs1_tag == mem_dest_tag)) ||
                   (wb_valid && (id_rs1_tag == wb_tag));
  assign rs2_fwd = (ex_we && !ex_is_load && (id_rs2_tag == ex_dest_tag)) ||
                   (mem_we && (id_rs2_tag == mem_dest_tag)) ||
                   (wb_valid && (id_rs2_tag == wb_tag));

  assign rs1_haz = id_rs1_used && (id_rs1_tag != '0) && busy_q[id_rs1_tag] && !rs1_fwd;
  assign rs2_haz = id_rs2_used && (id_rs2_tag != '0) && busy_q[id_rs2_tag] && !rs2_fwd;
  assign hazard  = id_valid && (rs1_haz || rs2_haz);

  // ---------------------------------------------------------------------
  // Event priority: memory freeze > flush > hazard > run
  // ---------------------------------------------------------------------
  // A pending flush can only exist while parked in MEM_WAIT, so it is
  // honoured on the first cycle that state sees dmem_stall drop.
  logic flush_take, flush_now, hold_now, alloc_en;

  assign flush_take = redirect || ((state_q == MEM_WAIT) && flush_pending_q);
  assign flush_now  = !dmem_stall && flush_take;
  assign hold_now   = !dmem_stall && !flush_take && hazard;
  assign alloc_en   = !dmem_stall && !flush_take && !hazard && alloc_valid;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst_n) begin
      // Reset values are driven combinationally so they appear as soon
      // as rst_n falls, not at the next edge.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (dmem_stall) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (flush_now) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (hold_now) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d         = RUN;
    flush_pending_d = 1'b0;
    if (dmem_stall) begin
      state_d         = MEM_WAIT;
      flush_pending_d = flush_pending_q || redirect;
    end else if (flush_take) begin
      state_d = RUN;
    end else if (hazard) begin
      state_d = LU_STALL;
    end
  end

  assign stall_cycles_d = if_id_we ? stall_cycles_q : stall_cycles_q + 32'd1;

  // ---------------------------------------------------------------------
  // Scoreboard: one bit per physical tag. Within a tag the WB/squash
  // clear is applied first and the allocation set last, so a same-cycle
  // alloc wins. Tag 0 is the hardwired zero register and never busy.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHYS; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_tag
        logic clr_hit, set_hit;
        assign clr_hit = (wb_valid && (wb_tag == TAG_W'(gi))) ||
                         (flush_now && squash_valid && (squash_tag == TAG_W'(gi)));
        assign set_hit = alloc_en && (alloc_tag == TAG_W'(gi));
        assign busy_d[gi] = dmem_stall ? busy_q[gi]
                                       : (set_hit || (busy_q[gi] && !clr_hit));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      flush_pending_q <= 1'b0;
      busy_q          <= '0;
      stall_cycles_q  <= '0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      busy_q          <= busy_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign busy_vec     = busy_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the renamed 5-stage RV32I core. It keeps a per-physical-register busy scoreboard and detects load-use and unforwardable RAW hazards for the instruction in ID. It sequences pipeline-register write enables, bubbles and flushes for three events: hazard stalls, data-memory waits and EX-stage redirects. It complements the EX-stage forwarding unit by guaranteeing that every source tag is either ready in the PRF or forwardable (EX/MEM alu_out for non-loads, WB regfilemux_out) by the time its consumer reaches EX.

## Interface
Parameters:
- NUM_PHYS, 64, physical register count; tag 0 is hardwired zero and is never busy.
- TAG_W, 6, physical tag width; must equal clog2(NUM_PHYS).

Ports:
- clk  in  1  core clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_used, id_rs2_used  in  1 each  the source is read.
- id_rs1_tag, id_rs2_tag  in  TAG_W each  source physical tags.
- alloc_valid  in  1  rename allocated a destination for the ID instruction.
- alloc_tag  in  TAG_W  the allocated destination tag.
- ex_we, ex_is_load  in  1 each  ID/EX instruction writes a register / is a load.
- ex_dest_tag  in  TAG_W  ID/EX destination tag.
- mem_we  in  1  EX/MEM instruction writes a register.
- mem_dest_tag  in  TAG_W  EX/MEM destination tag.
- wb_valid  in  1  MEM/WB writes the PRF this cycle.
- wb_tag  in  TAG_W  the WB destination tag.
- dmem_stall  in  1  MEM stage waiting on a data-memory response.
- redirect  in  1  EX resolved a mispredict; younger instructions die.
- squash_valid  in  1  the killed ID instruction's destination allocation is valid.
- squash_tag  in  TAG_W  that destination tag.
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  pipeline register enables.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- if_id_flush  out  1  load a NOP into IF/ID.
- busy_vec  out  NUM_PHYS  scoreboard state.
- stall_cycles  out  32  wrapping count of cycles with if_id_we=0.

## Operation
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset state is RUN.
- On reset:
  - busy_vec=0, stall_cycles=0, flush_pending=0.
  - All *_we=0, id_ex_bubble=1, if_id_flush=1.
- Source hazard definition (per source): used && tag!=0 && busy[tag] && not forwardable.
  - Forwardable means tag==ex_dest_tag with ex_we && !ex_is_load; or tag==mem_dest_tag with mem_we; or tag==wb_tag with wb_valid.
  - A load in ID/EX matching the tag is therefore always a hazard.
  - hazard = id_valid && (rs1 hazard || rs2 hazard).
- Priority, highest first: dmem_stall > redirect (or flush_pending) > hazard.
- dmem_stall=1:
  - All *_we=0, no bubble, no flush; state goes to MEM_WAIT.
  - Scoreboard updates are suppressed.
  - A redirect seen while stalled sets flush_pending.
- Redirect, or flush_pending with dmem_stall=0:
  - if_id_flush=1, id_ex_bubble=1, all *_we=1.
  - busy[squash_tag] is cleared if squash_valid.
  - The ID allocation is ignored.
  - flush_pending is cleared; state goes to RUN.
- Hazard:
  - pc_we=if_id_we=0, id_ex_bubble=1; ex_mem_we=mem_wb_we=1.
  - alloc_valid is ignored; state goes to LU_STALL.
  - The hazard is re-evaluated each cycle; the state returns to RUN when it clears.
- Otherwise all *_we=1 and no bubble/flush.
- Scoreboard, when not suppressed:
  - The wb_valid clear is applied first, then the alloc set.
  - Alloc wins when alloc_tag==wb_tag.
  - Writes to tag 0 are ignored.

## Timing
- All control outputs are combinational from the current state and inputs, with no added latency.
- busy_vec is registered; changes are visible the cycle after the event.
- A load-use pair costs exactly one bubble: the consumer stays in ID for one extra cycle and then forwards from WB.
- MEM_WAIT exits on the first cycle dmem_stall=0; that cycle behaves as RUN, or as a flush if flush_pending.
- stall_cycles increments on every edge where if_id_we=0, including dmem freezes. It wraps at 2^32.
- Asserting rst_n low mid-stall immediately drives the reset output values and clears pending flushes.

## Test plan
- Load writes p5 and is in ID/EX; ID reads p5 -> 1 cycle with pc_we=if_id_we=0, id_ex_bubble=1; next cycle all *_we=1; stall_cycles=1.
- ALU op writes p7 and is in ID/EX; ID reads p7 -> no stall; with busy[7]=1 and ID reading p7 once the producer has moved to EX/MEM -> no stall.
- dmem_stall high 3 cycles, with redirect in cycle 2 -> all *_we=0 for 3 cycles, then 1 cycle with if_id_flush=id_ex_bubble=1.
- Redirect with squash_valid=1, squash_tag=9, busy[9]=1 -> busy[9]=0 next cycle; the same-cycle alloc is ignored.
- wb_valid and alloc_valid both on tag 12 in one cycle -> busy[12]=1; alloc on tag 0 -> busy_vec[0] stays 0.
- rst_n dropped during LU_STALL -> outputs at reset values immediately; busy_vec=0 and state RUN after release.
